// File: rtl/axi_rob_pkg.sv
// Shared types for the AXI read-reorder path: internal RID layout {row,col},
// per-row outstanding counter and the AR skid-buffer states.
package axi_rob_pkg;

    localparam int NUM_ROWS_DEF = 4;
    localparam int NUM_COLS_DEF = 4;
    localparam int ROW_W        = (NUM_ROWS_DEF > 1) ? $clog2(NUM_ROWS_DEF) : 1;
    localparam int COL_W        = (NUM_COLS_DEF > 1) ? $clog2(NUM_COLS_DEF) : 1;
    localparam int CNT_W        = $clog2(NUM_COLS_DEF + 1);

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        row_t row;
        col_t col;
    } rid_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    function automatic rid_t make_rid(input row_t row, input col_t col);
        rid_t rid;
        rid.row = row;
        rid.col = col;
        return rid;
    endfunction

endpackage

// File: rtl/ar_if.sv
// AXI read-address channel bundle; receiver/sender modports for the master and slave sides.
interface ar_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4
);
    logic              valid;
    logic              ready;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [TAG_W-1:0]  tagid;

    modport sender   (output valid, id, addr, len, size, burst, tagid, input  ready);
    modport receiver (input  valid, id, addr, len, size, burst, tagid, output ready);
endinterface

// File: rtl/ar_id_remap_allocator_lowest_zero_finder.sv
// Priority encoder returning the lowest index whose bit is 0, plus a found flag.
module lowest_zero_finder #(
    parameter int W     = 4,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the last hit written is the lowest index.
        for (int i = W - 1; i >= 0; i--) begin
            if (!vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ar_id_remap_allocator.sv
// Maps master ARIDs onto internal {row,col} RIDs, forwards AR through a one-entry skid,
// and keeps the INTERNAL->ORIGINAL restore map. Optional stall counter: AR_REMAP_STALL_CNT_EN.
module ar_id_remap_allocator
    import axi_rob_pkg::*;
#(
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int NUM_COLS   = NUM_COLS_DEF,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    ar_if.receiver              ar_in_if,
    ar_if.sender                ar_out_if,
    output logic                alloc_evt_valid,
    output logic [ROW_W-1:0]    alloc_evt_row,
    output logic [COL_W-1:0]    alloc_evt_col,
    input  logic                free_req,
    input  logic [ROW_W-1:0]    free_row,
    input  logic [COL_W-1:0]    free_col,
    input  logic [ROW_W-1:0]    lookup_row,
    input  logic [COL_W-1:0]    lookup_col,
    output logic [ID_WIDTH-1:0] restored_id,
`ifdef AR_REMAP_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                free_err
);

    localparam cnt_t CNT_FULL = cnt_t'(NUM_COLS);

    // Slot table
    logic [NUM_ROWS-1:0] row_vld_q, row_vld_d;
    logic [ID_WIDTH-1:0] row_id_q   [NUM_ROWS];
    logic [ID_WIDTH-1:0] row_id_d   [NUM_ROWS];
    logic [NUM_COLS-1:0] col_busy_q [NUM_ROWS];
    logic [NUM_COLS-1:0] col_busy_d [NUM_ROWS];
    cnt_t                cnt_q      [NUM_ROWS];
    cnt_t                cnt_d      [NUM_ROWS];
    logic [ID_WIDTH-1:0] orig_id_q  [NUM_ROWS][NUM_COLS];
    logic [ID_WIDTH-1:0] orig_id_d  [NUM_ROWS][NUM_COLS];
    logic                free_err_q, free_err_d;

    // Skid register
    skid_state_e           skid_q, skid_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [7:0]            out_len_q, out_len_d;
    logic [2:0]            out_size_q, out_size_d;
    logic [1:0]            out_burst_q, out_burst_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

    // Allocation decision
    logic [NUM_ROWS-1:0] hit_vec;
    logic                hit;
    row_t                hit_row;
    row_t                free_row_idx;
    logic                free_row_found;
    row_t                tgt_row;
    logic [NUM_COLS-1:0] tgt_busy;
    col_t                tgt_col;
    logic                tgt_col_found;
    logic                grant;
    logic                in_ready;
    logic                accept;
    logic                free_hit;

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_hit
        assign hit_vec[gi] = row_vld_q[gi] && (row_id_q[gi] == ar_in_if.id);
    end

    // At most one row can match, so the lowest set bit of hit_vec is the hit row.
    lowest_zero_finder #(.W(NUM_ROWS)) u_hit_pick (
        .vec_i   (~hit_vec),
        .idx_o   (hit_row),
        .found_o (hit)
    );

    lowest_zero_finder #(.W(NUM_ROWS)) u_row_pick (
        .vec_i   (row_vld_q),
        .idx_o   (free_row_idx),
        .found_o (free_row_found)
    );

    assign tgt_row  = hit ? hit_row : free_row_idx;
    assign tgt_busy = col_busy_q[tgt_row];

    lowest_zero_finder #(.W(NUM_COLS)) u_col_pick (
        .vec_i   (tgt_busy),
        .idx_o   (tgt_col),
        .found_o (tgt_col_found)
    );

    assign grant    = tgt_col_found && (hit ? (cnt_q[hit_row] < CNT_FULL) : free_row_found);
    // rst gates ready so nothing is offered to the master while the table is held in reset.
    assign in_ready = rst && grant && ((skid_q == SKID_EMPTY) || ar_out_if.ready);
    assign accept   = ar_in_if.valid && in_ready;
    assign free_hit = free_req && col_busy_q[free_row][free_col];

    always_comb begin
        row_vld_d  = row_vld_q;
        row_id_d   = row_id_q;
        col_busy_d = col_busy_q;
        cnt_d      = cnt_q;
        orig_id_d  = orig_id_q;
        free_err_d = free_err_q | (free_req && !free_hit);
        if (free_hit) begin
            col_busy_d[free_row][free_col] = 1'b0;
        end
        if (accept) begin
            col_busy_d[tgt_row][tgt_col] = 1'b1;
            row_id_d[tgt_row]            = ar_in_if.id;
            orig_id_d[tgt_row][tgt_col]  = ar_in_if.id;
        end
        // Accept and free on the same row cancel in the counter; a row stays live while cnt > 0.
        for (int r = 0; r < NUM_ROWS; r++) begin
            cnt_d[r] = cnt_q[r]
                     + cnt_t'(accept && (tgt_row == row_t'(r)))
                     - cnt_t'(free_hit && (free_row == row_t'(r)));
            row_vld_d[r] = (cnt_d[r] != '0);
        end
    end

    always_comb begin
        skid_d      = skid_q;
        out_id_d    = out_id_q;
        out_addr_d  = out_addr_q;
        out_len_d   = out_len_q;
        out_size_d  = out_size_q;
        out_burst_d = out_burst_q;
        out_tag_d   = out_tag_q;
        case (skid_q)
            SKID_EMPTY: if (accept) skid_d = SKID_FULL;
            SKID_FULL:  if (ar_out_if.ready && !accept) skid_d = SKID_EMPTY;
            default:    skid_d = SKID_EMPTY;
        endcase
        // accept implies the skid is empty or draining this cycle, so loading never clobbers a held beat.
        if (accept) begin
            out_id_d    = ID_WIDTH'(make_rid(tgt_row, tgt_col));
            out_addr_d  = ar_in_if.addr;
            out_len_d   = ar_in_if.len;
            out_size_d  = ar_in_if.size;
            out_burst_d = ar_in_if.burst;
            out_tag_d   = ar_in_if.tagid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_vld_q  <= '0;
            free_err_q <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_id_q[r]   <= '0;
                col_busy_q[r] <= '0;
                cnt_q[r]      <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    orig_id_q[r][c] <= '0;
                end
            end
        end else begin
            row_vld_q  <= row_vld_d;
            row_id_q   <= row_id_d;
            col_busy_q <= col_busy_d;
            cnt_q      <= cnt_d;
            orig_id_q  <= orig_id_d;
            free_err_q <= free_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q      <= SKID_EMPTY;
            out_id_q    <= '0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_size_q  <= '0;
            out_burst_q <= '0;
            out_tag_q   <= '0;
        end else begin
            skid_q      <= skid_d;
            out_id_q    <= out_id_d;
            out_addr_q  <= out_addr_d;
            out_len_q   <= out_len_d;
            out_size_q  <= out_size_d;
            out_burst_q <= out_burst_d;
            out_tag_q   <= out_tag_d;
        end
    end

`ifdef AR_REMAP_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ar_in_if.valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign ar_in_if.ready  = in_ready;
    assign ar_out_if.valid = (skid_q == SKID_FULL);
    assign ar_out_if.id    = out_id_q;
    assign ar_out_if.addr  = out_addr_q;
    assign ar_out_if.len   = out_len_q;
    assign ar_out_if.size  = out_size_q;
    assign ar_out_if.burst = out_burst_q;
    assign ar_out_if.tagid = out_tag_q;

    assign alloc_evt_valid = accept;
    assign alloc_evt_row   = tgt_row;
    assign alloc_evt_col   = tgt_col;
    assign restored_id     = orig_id_q[lookup_row][lookup_col];
    assign free_err        = free_err_q;

endmodule
